// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: serialises the CPU's instruction and data sram-like
// channels onto one single-port synchronous RAM. Only one transaction is
// outstanding at a time, and the data channel has fixed priority.
// Handshake: ack pulses in the accept cycle, and rrdy pulses RAM_LAT+1
// cycles later.

module sram_like_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  input  logic              inst_sram_wr,
  input  logic [3:0]        inst_sram_cen,
  output logic              inst_sram_ack,
  output logic              inst_sram_rrdy,
  output logic [31:0]       inst_sram_rdata,

  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  input  logic              data_sram_wr,
  input  logic [3:0]        data_sram_cen,
  output logic              data_sram_ack,
  output logic              data_sram_rrdy,
  output logic [31:0]       data_sram_rdata,

  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_INST, GNT_DATA} grant_e;

  // A 3-bit counter covers the largest legal latency (7 -> load value 6).
  localparam int               CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

  state_e           state;
  grant_e           grant;
  logic [CNT_W-1:0] lat_cnt;
  logic             wr_q;

  logic inst_req;
  logic data_req;
  logic accept_inst;
  logic accept_data;

  // Byte-offset and high address bits are deliberately ignored (silent aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0,
                              inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0],
                              data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign inst_req = |inst_sram_cen;
  assign data_req = |data_sram_cen;

  // Acceptance is combinational so ack lands in the request cycle. Reset masks it,
  // which keeps every output low while rst is held.
  assign accept_data = !rst && (state == IDLE) && data_req;
  assign accept_inst = !rst && (state == IDLE) && !data_req && inst_req;

  assign data_sram_ack = accept_data;
  assign inst_sram_ack = accept_inst;

  // Drive the RAM port from the winning channel during the accept cycle only.
  always_comb begin
    // NOTE: every output gets a default first, so paths that assign nothing cannot infer a latch.
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (accept_data) begin
      ram_en    = 1'b1;
      ram_we    = data_sram_wr ? data_sram_cen : 4'b0000;
      ram_addr  = data_sram_addr[ADDR_W+1:2];
      ram_wdata = data_sram_wdata;
    end else if (accept_inst) begin
      ram_en    = 1'b1;
      ram_we    = inst_sram_wr ? inst_sram_cen : 4'b0000;
      ram_addr  = inst_sram_addr[ADDR_W+1:2];
      ram_wdata = inst_sram_wdata;
    end
  end

  // Transaction FSM: latches the grant, waits out the RAM latency, captures read data and pulses rrdy.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      state           <= IDLE;
      grant           <= GNT_NONE;
      lat_cnt         <= '0;
      wr_q            <= 1'b0;
      inst_sram_rrdy  <= 1'b0;
      data_sram_rrdy  <= 1'b0;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      inst_sram_rrdy <= 1'b0;
      data_sram_rrdy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_data) begin
            grant   <= GNT_DATA;
            wr_q    <= data_sram_wr;
            lat_cnt <= CNT_LOAD;
            state   <= WAIT;
          end else if (accept_inst) begin
            grant   <= GNT_INST;
            wr_q    <= inst_sram_wr;
            lat_cnt <= CNT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end else begin
            // Writes complete with rrdy too, but leave the read-data register untouched.
            if (!wr_q) begin
              if (grant == GNT_DATA) data_sram_rdata <= ram_rdata;
              if (grant == GNT_INST) inst_sram_rdata <= ram_rdata;
            end
            data_sram_rrdy <= (grant == GNT_DATA);
            inst_sram_rrdy <= (grant == GNT_INST);
            state          <= RESP;
          end
        end
        RESP: begin
          grant <= GNT_NONE;
          state <= IDLE;
        end
        default: begin
          grant <= GNT_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter. dut0 runs with RAM_LAT=1 and dut1 runs with RAM_LAT=3.
// Each DUT has its own behavioural RAM. Stimulus pushes hand-computed
// expected pulses into a queue, and a negedge monitor pops and compares
// them as the DUTs present ack/rrdy.

module tb_sram_like_arbiter;

  typedef enum int {EV_DACK = 0, EV_IACK = 1, EV_DRRDY = 2, EV_IRRDY = 3} ev_e;

  typedef struct {
    int          k;
    ev_e         ev;
    int          cyc;
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] i_addr[2], i_wdata[2], d_addr[2], d_wdata[2];
  logic        i_wr[2], d_wr[2];
  logic [3:0]  i_cen[2], d_cen[2];
  logic        i_ack[2], i_rrdy[2], d_ack[2], d_rrdy[2];
  logic [31:0] i_rdata[2], d_rdata[2];
  logic        ram_en[2];
  logic [3:0]  ram_we[2];
  logic [15:0] ram_addr[2];
  logic [31:0] ram_wdata[2], ram_rdata[2];

  sram_like_arbiter #(.ADDR_W(16), .RAM_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .inst_sram_addr(i_addr[0]), .inst_sram_wdata(i_wdata[0]), .inst_sram_wr(i_wr[0]),
    .inst_sram_cen(i_cen[0]), .inst_sram_ack(i_ack[0]), .inst_sram_rrdy(i_rrdy[0]),
    .inst_sram_rdata(i_rdata[0]),
    .data_sram_addr(d_addr[0]), .data_sram_wdata(d_wdata[0]), .data_sram_wr(d_wr[0]),
    .data_sram_cen(d_cen[0]), .data_sram_ack(d_ack[0]), .data_sram_rrdy(d_rrdy[0]),
    .data_sram_rdata(d_rdata[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
  );

  sram_like_arbiter #(.ADDR_W(16), .RAM_LAT(3)) dut1 (
    .clk(clk), .rst(rst),
    .inst_sram_addr(i_addr[1]), .inst_sram_wdata(i_wdata[1]), .inst_sram_wr(i_wr[1]),
    .inst_sram_cen(i_cen[1]), .inst_sram_ack(i_ack[1]), .inst_sram_rrdy(i_rrdy[1]),
    .inst_sram_rdata(i_rdata[1]),
    .data_sram_addr(d_addr[1]), .data_sram_wdata(d_wdata[1]), .data_sram_wr(d_wr[1]),
    .data_sram_cen(d_cen[1]), .data_sram_ack(d_ack[1]), .data_sram_rrdy(d_rrdy[1]),
    .data_sram_rdata(d_rdata[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
  );

  // Behavioural RAMs. Each one is preloaded on the first edge. Read data
  // appears RAM_LAT cycles after ram_en, and garbage is shown whenever no read is due.
  logic [31:0] mem [2][64];
  logic [31:0] pipe [2][3];
  logic [31:0] merged;
  bit          loaded;

  always @(posedge clk) begin
    if (!loaded) begin
      loaded       <= 1'b1;
      mem[0][6'h10] <= 32'hDEADBEEF;
      mem[0][6'h01] <= 32'h11223344;
      mem[0][6'h02] <= 32'hCAFEF00D;
      mem[0][6'h03] <= 32'h01020304;
      mem[1][6'h10] <= 32'h0BADF00D;
      mem[1][6'h11] <= 32'h12345678;
    end else begin
      for (int k = 0; k < 2; k++) begin
        merged = mem[k][ram_addr[k][5:0]];
        for (int b = 0; b < 4; b++)
          if (ram_we[k][b]) merged[8*b +: 8] = ram_wdata[k][8*b +: 8];
        if (ram_en[k] && (ram_we[k] != 4'h0)) mem[k][ram_addr[k][5:0]] <= merged;
      end
    end
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= ram_en[k] ? mem[k][ram_addr[k][5:0]] : 32'hBAD0BAD0;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int k, input ev_e ev, input int c, input logic [15:0] a,
                           input logic [3:0] we, input logic [31:0] d);
    exp_t e;
    e.k = k; e.ev = ev; e.cyc = c; e.addr = a; e.we = we; e.data = d;
    sb.push_back(e);
  endtask

  task automatic observe(input int k, input ev_e ev);
    exp_t  e;
    string tag;
    tag = $sformatf("dut%0d %s", k, ev.name());
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected %s at cycle %0d: got a pulse, expected none", tag, cyc);
      return;
    end
    e = sb.pop_front();
    check({tag, " event"}, {k, int'(ev)}, {e.k, int'(e.ev)});
    check({tag, " cycle"}, 64'(cyc), 64'(e.cyc));
    case (ev)
      EV_DACK, EV_IACK: begin
        check({tag, " ram_addr"},  64'(ram_addr[k]),  64'(e.addr));
        check({tag, " ram_we"},    64'(ram_we[k]),    64'(e.we));
        check({tag, " ram_wdata"}, 64'(ram_wdata[k]), 64'(e.data));
      end
      EV_DRRDY: check({tag, " rdata"}, 64'(d_rdata[k]), 64'(e.data));
      default:  check({tag, " rdata"}, 64'(i_rdata[k]), 64'(e.data));
    endcase
  endtask

  // Monitor: per-cycle handshake invariants, plus scoreboard pops for every pulse.
  logic [3:0] pulses;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pulses = {i_rrdy[k], d_rrdy[k], i_ack[k], d_ack[k]};
      check($sformatf("dut%0d one_pulse", k), 64'($countones(pulses) <= 1), 64'd1);
      check($sformatf("dut%0d ram_en_vs_ack", k), 64'(ram_en[k]), 64'(i_ack[k] | d_ack[k]));
      check($sformatf("dut%0d ram_we_idle", k), 64'(ram_en[k] ? 4'h0 : ram_we[k]), 64'd0);
      for (int e = 0; e < 4; e++)
        if (pulses[e]) observe(k, ev_e'(e));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input int k, input logic [31:0] a, input logic [31:0] wd,
                          input logic wr, input logic [3:0] cen);
    i_addr[k] = a; i_wdata[k] = wd; i_wr[k] = wr; i_cen[k] = cen;
  endtask

  task automatic set_data(input int k, input logic [31:0] a, input logic [31:0] wd,
                          input logic wr, input logic [3:0] cen);
    d_addr[k] = a; d_wdata[k] = wd; d_wr[k] = wr; d_cen[k] = cen;
  endtask

  task automatic check_all_low(input string tag);
    check({tag, " inst_ack"},   64'(i_ack[0]),   64'd0);
    check({tag, " data_ack"},   64'(d_ack[0]),   64'd0);
    check({tag, " inst_rrdy"},  64'(i_rrdy[0]),  64'd0);
    check({tag, " data_rrdy"},  64'(d_rrdy[0]),  64'd0);
    check({tag, " ram_en"},     64'(ram_en[0]),  64'd0);
    check({tag, " ram_we"},     64'(ram_we[0]),  64'd0);
    check({tag, " inst_rdata"}, 64'(i_rdata[0]), 64'd0);
    check({tag, " data_rdata"}, 64'(d_rdata[0]), 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, expected it to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_inst(k, 32'h0, 32'h0, 1'b0, 4'h0);
      set_data(k, 32'h0, 32'h0, 1'b0, 4'h0);
    end
    step(2);

    // Reset state, with both requests presented while rst is held.
    set_inst(0, 32'h40, 32'h0, 1'b0, 4'hF);
    set_data(0, 32'h40, 32'h0, 1'b0, 4'hF);
    #1;
    check_all_low("reset");
    set_inst(0, 32'h0, 32'h0, 1'b0, 4'h0);
    set_data(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(1);
    rst = 1'b0;
    step(1);

    // Single instruction read with the boot address aliasing to word 0x10.
    t = cyc;
    set_inst(0, 32'hBFC00040, 32'h0, 1'b0, 4'hF);
    expect_ev(0, EV_IACK,  t,     16'h0010, 4'h0, 32'h0);
    expect_ev(0, EV_IRRDY, t + 2, 16'h0,    4'h0, 32'hDEADBEEF);
    step(1);
    set_inst(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(3);

    // Byte write to byte 1 of word 1. The write's rrdy leaves data_rdata at its reset value.
    t = cyc;
    set_data(0, 32'h6, 32'h0000AB00, 1'b1, 4'b0010);
    expect_ev(0, EV_DACK,  t,     16'h0001, 4'b0010, 32'h0000AB00);
    expect_ev(0, EV_DRRDY, t + 2, 16'h0,    4'h0,    32'h0);
    step(1);
    set_data(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(2);
    t = cyc;
    set_data(0, 32'h4, 32'h0, 1'b0, 4'hF);
    expect_ev(0, EV_DACK,  t,     16'h0001, 4'h0, 32'h0);
    expect_ev(0, EV_DRRDY, t + 2, 16'h0,    4'h0, 32'h1122AB44);
    step(1);
    set_data(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(3);

    // Contention: data wins. Inst (aliased address 0xABCC000B -> word 2) is acked at T+3.
    t = cyc;
    set_inst(0, 32'hABCC000B, 32'h0, 1'b0, 4'hF);
    set_data(0, 32'h40,       32'h0, 1'b0, 4'hF);
    expect_ev(0, EV_DACK,  t,     16'h0010, 4'h0, 32'h0);
    expect_ev(0, EV_DRRDY, t + 2, 16'h0,    4'h0, 32'hDEADBEEF);
    expect_ev(0, EV_IACK,  t + 3, 16'h0002, 4'h0, 32'h0);
    expect_ev(0, EV_IRRDY, t + 5, 16'h0,    4'h0, 32'hCAFEF00D);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      if (i == 1) set_data(0, 32'h0, 32'h0, 1'b0, 4'h0);
      if (i == 4) set_inst(0, 32'h0, 32'h0, 1'b0, 4'h0);
      check($sformatf("contention inst_rdata held T+%0d", i), 64'(i_rdata[0]), 64'hDEADBEEF);
    end
    step(3);

    // Reset in the cycle after ack: all outputs drop at once and no rrdy appears.
    t = cyc;
    set_inst(0, 32'hBFC00040, 32'h0, 1'b0, 4'hF);
    expect_ev(0, EV_IACK, t, 16'h0010, 4'h0, 32'h0);
    step(1);
    set_inst(0, 32'h0, 32'h0, 1'b0, 4'h0);
    rst = 1'b1;
    #1;
    check_all_low("mid-op reset");
    step(2);
    rst = 1'b0;
    t = cyc;
    set_data(0, 32'h4, 32'h0, 1'b0, 4'hF);
    expect_ev(0, EV_DACK,  t,     16'h0001, 4'h0, 32'h0);
    expect_ev(0, EV_DRRDY, t + 2, 16'h0,    4'h0, 32'h1122AB44);
    step(1);
    set_data(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(3);

    // Withdrawn inst request, presented for one cycle while data is in WAIT.
    t = cyc;
    set_data(0, 32'h8, 32'h0, 1'b0, 4'hF);
    expect_ev(0, EV_DACK,  t,     16'h0002, 4'h0, 32'h0);
    expect_ev(0, EV_DRRDY, t + 2, 16'h0,    4'h0, 32'hCAFEF00D);
    step(1);
    set_data(0, 32'h0, 32'h0, 1'b0, 4'h0);
    set_inst(0, 32'h40, 32'h0, 1'b0, 4'hF);
    step(1);
    set_inst(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(3);

    // An inst-channel write is honoured. A following read sees the merged bytes.
    t = cyc;
    set_inst(0, 32'hC, 32'h55AA0000, 1'b1, 4'b1100);
    expect_ev(0, EV_IACK,  t,     16'h0003, 4'b1100, 32'h55AA0000);
    expect_ev(0, EV_IRRDY, t + 2, 16'h0,    4'h0,    32'h0);
    step(1);
    set_inst(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(2);
    t = cyc;
    set_inst(0, 32'hC, 32'h0, 1'b0, 4'hF);
    expect_ev(0, EV_IACK,  t,     16'h0003, 4'h0, 32'h0);
    expect_ev(0, EV_IRRDY, t + 2, 16'h0,    4'h0, 32'h55AA0304);
    step(1);
    set_inst(0, 32'h0, 32'h0, 1'b0, 4'h0);
    step(3);

    // RAM_LAT=3: rrdy 4 cycles after ack, and a held follow-on request is acked 5 cycles later.
    t = cyc;
    set_inst(1, 32'h40, 32'h0, 1'b0, 4'hF);
    expect_ev(1, EV_IACK,  t,     16'h0010, 4'h0, 32'h0);
    expect_ev(1, EV_IRRDY, t + 4, 16'h0,    4'h0, 32'h0BADF00D);
    step(1);
    set_inst(1, 32'h44, 32'h0, 1'b0, 4'hF);
    expect_ev(1, EV_IACK,  t + 5, 16'h0011, 4'h0, 32'h0);
    expect_ev(1, EV_IRRDY, t + 9, 16'h0,    4'h0, 32'h12345678);
    step(5);
    set_inst(1, 32'h0, 32'h0, 1'b0, 4'h0);
    step(6);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
